// File: rtl/value_membank_pkg.sv
// Shared types and default sizing for the multi-channel value memory bank.
package value_membank_pkg;

  localparam int unsigned N_CH_DEF   = 32;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned DEPTH_DEF  = 1024;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

endpackage

// File: rtl/value_membank_if.sv
// Writer/reader/control bundle of the value memory bank; master = pipeline side, slave = bank.
interface value_membank_if
  import value_membank_pkg::*;
#(
  parameter int unsigned N_CH   = N_CH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH_DEF)
) ();

  logic                     start_init;
  logic [DATA_W-1:0]        init_val;
  logic [N_CH-1:0]          wren;
  logic [ADDR_W-1:0]        wraddr;
  logic [N_CH*DATA_W-1:0]   wr_data;
  logic                     rden;
  logic [ADDR_W-1:0]        rdaddr;
  logic [N_CH*DATA_W-1:0]   rd_data;
  logic                     rd_valid;
  logic                     busy;
  logic                     done_init;
  logic                     wr_reject;

  modport master (
    output start_init, init_val, wren, wraddr, wr_data, rden, rdaddr,
    input  rd_data, rd_valid, busy, done_init, wr_reject
  );

  modport slave (
    input  start_init, init_val, wren, wraddr, wr_data, rden, rdaddr,
    output rd_data, rd_valid, busy, done_init, wr_reject
  );

endinterface

// File: rtl/value_membank_mc_ram.sv
// Single-clock simple dual-port RAM: one write port, registered read held between read enables.
module mem_sdp_ram #(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned DEPTH  = 1024,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Array contents are never reset; only the output register is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/value_membank_mc.sv
// N_CH-channel value memory bank with init sweep. Optional macro
// VALUE_MEMBANK_RDW_BYPASS_EN returns new data on same-cycle same-address read/write.
module value_membank_mc
  import value_membank_pkg::*;
#(
  parameter int unsigned N_CH   = N_CH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            nrst,
  value_membank_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t                 r_state;
  logic [ADDR_W-1:0]      r_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_wr_reject;
  logic                   r_rd_valid;

  logic [N_CH-1:0]        w_we;
  logic [ADDR_W-1:0]      w_waddr;
  logic [N_CH*DATA_W-1:0] w_wdata;
  logic [N_CH*DATA_W-1:0] w_ram_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start_init) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (bus.start_init) begin
            r_cnt <= '0;
          end else if (r_cnt == LAST_ADDR) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.start_init) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sweep owns every channel's write port while busy; external writes are dropped.
  always_comb begin
    w_we    = r_busy ? '1 : bus.wren;
    w_waddr = r_busy ? r_cnt : bus.wraddr;
    w_wdata = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      w_wdata[c*DATA_W +: DATA_W] = r_busy ? bus.init_val : bus.wr_data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_reject <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_wr_reject <= r_busy && (|bus.wren);
      r_rd_valid  <= bus.rden;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    mem_sdp_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_ram (
      .clk     (clk),
      .rst_n   (nrst),
      .i_we    (w_we[g]),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata[g*DATA_W +: DATA_W]),
      .i_re    (bus.rden),
      .i_raddr (bus.rdaddr),
      .o_rdata (w_ram_q[g*DATA_W +: DATA_W])
    );
  end

`ifdef VALUE_MEMBANK_RDW_BYPASS_EN
  logic [N_CH-1:0]        r_byp_hit;
  logic [N_CH*DATA_W-1:0] r_byp_data;

  // Hit flag and write data are captured alongside the RAM read register, so the
  // selection after it is cycle-equivalent to a mux ahead of the read register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_byp_hit  <= '0;
      r_byp_data <= '0;
    end else if (bus.rden) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        r_byp_hit[c] <= w_we[c] && (w_waddr == bus.rdaddr);
      end
      r_byp_data <= w_wdata;
    end
  end

  always_comb begin
    bus.rd_data = w_ram_q;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (r_byp_hit[c]) bus.rd_data[c*DATA_W +: DATA_W] = r_byp_data[c*DATA_W +: DATA_W];
    end
  end
`else
  assign bus.rd_data = w_ram_q;
`endif

  assign bus.rd_valid  = r_rd_valid;
  assign bus.busy      = r_busy;
  assign bus.done_init = r_done;
  assign bus.wr_reject = r_wr_reject;

endmodule

// File: tb/tb_value_membank_mc.sv
// Directed self-checking bench for value_membank_mc (N_CH=4, DATA_W=16, DEPTH=16).
module tb_value_membank_mc;

  localparam int unsigned NC = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned DP = 16;
  localparam int unsigned AW = 4;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  value_membank_if #(.N_CH(NC), .DATA_W(DW), .ADDR_W(AW)) bif ();

  value_membank_mc #(.N_CH(NC), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    bif.rden   = 1'b1;
    bif.rdaddr = a;
    tick();
    bif.rden   = 1'b0;
  endtask

  // start_init at edge E, then observe 20 cycles (after E .. E+19).
  task automatic run_init(input logic [DW-1:0] v, output int busy_n, output int done_n,
                          output int done_idx);
    bif.init_val   = v;
    bif.start_init = 1'b1;
    tick();
    bif.start_init = 1'b0;
    busy_n = 0; done_n = 0; done_idx = -1;
    for (int i = 0; i < 20; i++) begin
      if (bif.busy === 1'b1) busy_n++;
      if (bif.done_init === 1'b1) begin done_n++; done_idx = i; end
      tick();
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bif.start_init = 1'b0; bif.init_val = '0; bif.wren = '0; bif.wraddr = '0;
    bif.wr_data = '0; bif.rden = 1'b0; bif.rdaddr = '0;
    #3;
    checks++; if (bif.rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", bif.rd_data); end
    checks++; if (bif.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", bif.rd_valid); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bif.busy); end
    checks++; if (bif.done_init !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bif.done_init); end
    checks++; if (bif.wr_reject !== 1'b0) begin errors++; $display("FAIL reset_wr_reject got %b exp 0", bif.wr_reject); end
    tick(); tick();
    #2 nrst = 1'b1;
    tick();
  endtask

  task automatic test_init();
    int b, d, di;
    run_init(16'h00A5, b, d, di);
    checks++; if (b != 16) begin errors++; $display("FAIL init_busy_cycles got %0d exp 16", b); end
    checks++; if (d != 1) begin errors++; $display("FAIL init_done_count got %0d exp 1", d); end
    checks++; if (di != 16) begin errors++; $display("FAIL init_done_pos got %0d exp 16", di); end
    for (int a = 0; a < 16; a++) begin
      rd(AW'(a));
      checks++;
      if (bif.rd_data !== {4{16'h00A5}}) begin
        errors++; $display("FAIL init_read addr %0d got %h exp %h", a, bif.rd_data, {4{16'h00A5}});
      end
    end
  endtask

  task automatic test_masked_write();
    bif.wren    = 4'b0101;
    bif.wraddr  = 4'd3;
    bif.wr_data = {16'd4, 16'd3, 16'd2, 16'd1};
    tick();
    bif.wren = '0;
    checks++; if (bif.wr_reject !== 1'b0) begin errors++; $display("FAIL idle_wr_reject got %b exp 0", bif.wr_reject); end
    rd(4'd3);
    checks++; if (bif.rd_valid !== 1'b1) begin errors++; $display("FAIL mask_rd_valid got %b exp 1", bif.rd_valid); end
    checks++;
    if (bif.rd_data !== {16'h00A5, 16'h0003, 16'h00A5, 16'h0001}) begin
      errors++; $display("FAIL mask_read got %h exp %h", bif.rd_data, {16'h00A5, 16'h0003, 16'h00A5, 16'h0001});
    end
    tick();
    checks++; if (bif.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got %b exp 0", bif.rd_valid); end
    checks++;
    if (bif.rd_data !== {16'h00A5, 16'h0003, 16'h00A5, 16'h0001}) begin
      errors++; $display("FAIL rd_data_hold got %h exp %h", bif.rd_data, {16'h00A5, 16'h0003, 16'h00A5, 16'h0001});
    end
  endtask

  task automatic test_busy_reject();
    bif.init_val   = 16'h00A5;
    bif.start_init = 1'b1;
    tick();
    bif.start_init = 1'b0;
    repeat (9) tick();
    // Address 2 was already swept at this point, so an accepted write would stick.
    bif.wren    = 4'hF;
    bif.wraddr  = 4'd2;
    bif.wr_data = {4{16'h0077}};
    tick();
    bif.wren = '0;
    checks++; if (bif.wr_reject !== 1'b1) begin errors++; $display("FAIL wr_reject_pulse got %b exp 1", bif.wr_reject); end
    tick();
    checks++; if (bif.wr_reject !== 1'b0) begin errors++; $display("FAIL wr_reject_clear got %b exp 0", bif.wr_reject); end
    repeat (10) tick();
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reject_sweep_end got %b exp 0", bif.busy); end
    rd(4'd2);
    checks++;
    if (bif.rd_data !== {4{16'h00A5}}) begin
      errors++; $display("FAIL reject_retains got %h exp %h", bif.rd_data, {4{16'h00A5}});
    end
  endtask

  task automatic test_restart();
    int b, d, di;
    int d_pre;
    d_pre = 0;
    bif.init_val   = 16'h00A5;
    bif.start_init = 1'b1;
    tick();
    bif.start_init = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bif.done_init === 1'b1) d_pre++;
    end
    run_init(16'h00A5, b, d, di);
    checks++; if (b != 16) begin errors++; $display("FAIL restart_busy_cycles got %0d exp 16", b); end
    checks++; if (d + d_pre != 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", d + d_pre); end
    checks++; if (di != 16) begin errors++; $display("FAIL restart_done_pos got %0d exp 16", di); end
  endtask

  task automatic test_reset_mid();
    int b, d, di;
    int d_after, b_after;
    d_after = 0; b_after = 0;
    bif.init_val   = 16'h00A5;
    bif.start_init = 1'b1;
    tick();
    bif.start_init = 1'b0;
    repeat (4) tick();
    #2 nrst = 1'b0;
    #1;
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bif.busy); end
    checks++; if (bif.rd_data !== 64'h0) begin errors++; $display("FAIL midrst_rd_data got %h exp 0", bif.rd_data); end
    checks++; if (bif.done_init !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", bif.done_init); end
    tick();
    #2 nrst = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bif.done_init === 1'b1) d_after++;
      if (bif.busy === 1'b1) b_after++;
    end
    checks++; if (d_after != 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", d_after); end
    checks++; if (b_after != 0) begin errors++; $display("FAIL midrst_idle got %0d exp 0", b_after); end
    run_init(16'h005A, b, d, di);
    checks++; if (b != 16 || d != 1) begin errors++; $display("FAIL midrst_reinit got busy %0d done %0d exp 16 1", b, d); end
    rd(4'd9);
    checks++;
    if (bif.rd_data !== {4{16'h005A}}) begin
      errors++; $display("FAIL midrst_read got %h exp %h", bif.rd_data, {4{16'h005A}});
    end
  endtask

  task automatic test_rdw();
    logic [63:0] exp_rdw;
    bif.wren    = 4'hF;
    bif.wraddr  = 4'd5;
    bif.wr_data = {4{16'h0011}};
    tick();
    bif.wren    = 4'b0011;
    bif.wr_data = {4{16'h0022}};
    bif.rden    = 1'b1;
    bif.rdaddr  = 4'd5;
    tick();
    bif.wren = '0;
    bif.rden = 1'b0;
`ifdef VALUE_MEMBANK_RDW_BYPASS_EN
    exp_rdw = {16'h0011, 16'h0011, 16'h0022, 16'h0022};
`else
    exp_rdw = {4{16'h0011}};
`endif
    checks++; if (bif.rd_data !== exp_rdw) begin errors++; $display("FAIL rdw_same_cycle got %h exp %h", bif.rd_data, exp_rdw); end
    rd(4'd5);
    checks++;
    if (bif.rd_data !== {16'h0011, 16'h0011, 16'h0022, 16'h0022}) begin
      errors++; $display("FAIL rdw_after got %h exp %h", bif.rd_data, {16'h0011, 16'h0011, 16'h0022, 16'h0022});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_init();
    test_masked_write();
    test_busy_reject();
    test_restart();
    test_reset_mid();
    test_rdw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/value_membank_mc.md
# value_membank_mc

Parametrised multi-channel value memory bank for lattice node values. It holds N_CH independent simple-dual-port memories sharing one read address and one write address, with a per-channel write mask. On a start_init pulse it sweeps every address of every channel to a programmable init value, then pulses done_init. It sits between the node-update pipeline (writer) and the value-fetch stage (reader), replacing fixed 32×64×1k banks.

## Interface
- N_CH, default 32: number of channels (memories)
- DATA_W, default 64: word width per channel
- DEPTH, default 1024: words per channel; power of two, ≥ 4
- ADDR_W, default $clog2(DEPTH): address width (derived, do not override)
- clk  in  1  single clock; all logic on rising edge
- nrst  in  1  reset, asynchronous assert, active-low
- start_init  in  1  pulse; begin (or restart) init sweep
- init_val  in  DATA_W  value written to all words during sweep; sampled every sweep cycle
- wren  in  N_CH  per-channel write enable
- wraddr  in  ADDR_W  write address
- wr_data  in  N_CH*DATA_W  packed write data, channel c at [c*DATA_W +: DATA_W]
- rden  in  1  read request
- rdaddr  in  ADDR_W  read address
- rd_data  out  N_CH*DATA_W  packed read data, same packing
- rd_valid  out  1  rd_data valid this cycle
- busy  out  1  init sweep in progress
- done_init  out  1  one-cycle pulse, sweep complete
- wr_reject  out  1  one-cycle pulse, external write dropped because busy

## Operation
- FSM states IDLE, SWEEP, DONE. Reset → IDLE.
- IDLE: start_init → SWEEP, sweep counter ← 0.
- SWEEP: each cycle write init_val to address cnt in all channels; cnt increments. At cnt == DEPTH-1 → DONE. start_init in SWEEP restarts: cnt ← 0, stays SWEEP.
- DONE: one cycle; done_init = 1. → IDLE, or → SWEEP (cnt ← 0) if start_init.
- busy = (state == SWEEP).
- External writes: channel c written when wren[c] && !busy. If busy && |wren: no external write, wr_reject pulses next cycle.
- Reads allowed in every state; addresses not yet swept return prior contents.
- Read-during-write, same address, same cycle: returns old data (see Configuration).
- Memory contents not reset; only control and output registers reset.
- Reset mid-sweep: immediate return to IDLE, busy/done_init low; memory partially initialised, no done_init produced.

## Timing
- Reset values: rd_data 0, rd_valid 0, busy 0, done_init 0, wr_reject 0.
- start_init sampled at edge E: busy high from E; sweep writes addr k at edge E+1+k; busy falls after edge E+DEPTH; done_init high in cycle after edge E+DEPTH. Total DEPTH busy cycles.
- Read latency 1: rden at edge E → rd_data/rd_valid valid after E, held until next rden; rd_valid high one cycle per request.
- Write takes effect at the sampling edge; a read one cycle later sees new data.
- wr_reject: registered, high the cycle after the rejected write.
- Counter is ADDR_W bits; never wraps past DEPTH-1 (terminal compare, not overflow).

## Configuration
- VALUE_MEMBANK_RDW_BYPASS_EN defined: same-cycle same-address read and write returns the newly written data per channel (respecting wren mask and sweep writes of init_val); bypass mux added before rd_data register.
- Undefined: read returns old memory contents; no bypass logic.

## Structure
- Package value_membank_pkg: FSM state enum (IDLE, SWEEP, DONE), default N_CH/DATA_W/DEPTH constants.
- One sub-module: mem_sdp_ram (DATA_W, DEPTH) — single-clock simple dual-port RAM, registered read, one write port with enable; instantiated N_CH times via generate. Top holds FSM, sweep counter, write mux, bypass.

## Test plan
- Reset, then start_init with DEPTH=16, init_val=0xA5 → busy 16 cycles, done_init single pulse at cycle 17; reading all 16 addresses in all channels returns 0xA5.
- After init, wren=0b0101 (N_CH=4), wraddr=3, data per channel 1,2,3,4 → read addr 3 returns {0xA5,3,0xA5,1} (ch3..ch0), rd_valid after 1 cycle.
- wren asserted while busy → write dropped, wr_reject pulses next cycle, address retains init_val after done.
- start_init re-pulsed at sweep cycle 8 → busy extends to 16 cycles from restart, exactly one done_init.
- nrst asserted mid-sweep → outputs zero asynchronously, no done_init; fresh start_init completes normally.
- Same-cycle read/write addr 5, old 0x11, new 0x22 → rd_data 0x22 with VALUE_MEMBANK_RDW_BYPASS_EN, 0x11 without.
